// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial two's-complement add/sub unit.
//   op_e    : operation select encoding driven on the op port
//   state_e : sequencer states of serial_twos_addsub
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_ABS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder: two half adders plus an OR for carry.
// Ports:
//   a_i, b_i, cin_i : addend bits and incoming carry
//   sum_o           : a ^ b ^ cin
//   cout_o          : carry out of this bit position
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic ha1_s_s;
  logic ha1_c_s;
  logic ha2_c_s;

  // first half adder on the operand bits
  assign ha1_s_s = a_i ^ b_i;
  assign ha1_c_s = a_i & b_i;

  // second half adder folds in the incoming carry
  assign sum_o   = ha1_s_s ^ cin_i;
  assign ha2_c_s = ha1_s_s & cin_i;

  assign cout_o  = ha1_c_s | ha2_c_s;

endmodule

// File: rtl/serial_twos_addsub.sv
// Bit-serial two's-complement ADD / SUB / NEG / ABS, one bit per clock, LSB first.
// Optional feature macro: ADDSUB_OVF_EN (signed overflow flag on ovf; tied 0 otherwise).
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, sampled only while idle
//   op         : 00 ADD a+b, 01 SUB a-b, 10 NEG -a, 11 ABS |a|
//   a, b       : operands (b unused for NEG/ABS)
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when result/carry_out/ovf become valid
//   result     : result, held until the next completed operation
//   carry_out  : carry out of the MSB cell
//   ovf        : signed overflow (ADDSUB_OVF_EN only)
module serial_twos_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   as_q, as_d;
  logic [WIDTH-1:0]   bs_q, bs_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               fa_sum_s;
  logic               fa_cout_s;
`ifdef ADDSUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  serial_fa_cell u_fa (
    .a_i    (as_q[0]),
    .b_i    (bs_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum_s),
    .cout_o (fa_cout_s)
  );

  // next-state logic: operand load, bit-serial shifting and completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    as_d        = as_q;
    bs_d        = bs_q;
    carry_d     = carry_q;
    shadow_d    = shadow_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
`ifdef ADDSUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_RUN;
          // subtraction and negation use ~x + 1 via the initial carry
          case (op_e'(op))
            OP_ADD: begin
              as_d = a;  bs_d = b;   carry_d = 1'b0;
            end
            OP_SUB: begin
              as_d = a;  bs_d = ~b;  carry_d = 1'b1;
            end
            OP_NEG: begin
              as_d = ~a; bs_d = '0;  carry_d = 1'b1;
            end
            OP_ABS: begin
              if (a[WIDTH-1]) begin
                as_d = ~a; bs_d = '0; carry_d = 1'b1;
              end else begin
                as_d = a;  bs_d = '0; carry_d = 1'b0;
              end
            end
            default: begin
              as_d = a;  bs_d = b;   carry_d = 1'b0;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        as_d     = {1'b0, as_q[WIDTH-1:1]};
        bs_d     = {1'b0, bs_q[WIDTH-1:1]};
        carry_d  = fa_cout_s;
        shadow_d = {fa_sum_s, shadow_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // MSB cell: publish the assembled word and the final carries
          state_d     = ST_DONE;
          result_d    = {fa_sum_s, shadow_q[WIDTH-1:1]};
          carry_out_d = fa_cout_s;
`ifdef ADDSUB_OVF_EN
          // carry_q is the carry into the MSB cell here
          ovf_d       = carry_q ^ fa_cout_s;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      as_q        <= '0;
      bs_q        <= '0;
      carry_q     <= 1'b0;
      shadow_q    <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      as_q        <= as_d;
      bs_q        <= bs_d;
      carry_q     <= carry_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

`ifdef ADDSUB_OVF_EN
  // overflow flag register, held alongside result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_twos_addsub.sv
// Directed and random checks of serial_twos_addsub at WIDTH=5 and WIDTH=16.
module tb_serial_twos_addsub;

`ifdef ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start5 = 1'b0;
  logic [1:0]  op5 = 2'b00;
  logic [4:0]  a5 = 5'd0, b5 = 5'd0;
  logic        busy5, done5, co5, ovf5;
  logic [4:0]  res5;

  logic        start16 = 1'b0;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic        busy16, done16, co16, ovf16;
  logic [15:0] res16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_twos_addsub #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .op(op5), .a(a5), .b(b5),
    .busy(busy5), .done(done5), .result(res5), .carry_out(co5), .ovf(ovf5)
  );

  serial_twos_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .carry_out(co16), .ovf(ovf16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one 5-bit operation from IDLE; returns the values seen in the done cycle.
  task automatic do_op5(input logic [1:0] o, input logic [4:0] av, input logic [4:0] bv,
                        output logic [4:0] r, output logic c, output logic v,
                        output int lat, output int bcnt, output logic pulse_ok);
    start5 = 1'b1; op5 = o; a5 = av; b5 = bv;
    step();
    start5 = 1'b0;
    a5 = ~av; b5 = ~bv;
    lat = 0; bcnt = 0;
    while (!done5 && lat < 20) begin
      if (busy5) bcnt++;
      step();
      lat++;
    end
    r = res5; c = co5; v = ovf5;
    step();
    pulse_ok = !done5 && !busy5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({busy5, done5, res5, co5, ovf5} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%b carry=%b ovf=%b want all 0",
               busy5, done5, res5, co5, ovf5);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_neg();
    logic [4:0] r; logic c, v, p; int lat, bc;
    do_op5(2'b10, 5'b00101, 5'b00000, r, c, v, lat, bc, p);
    checks++;
    if (r !== 5'b11011) begin errors++; $display("FAIL neg_result got %b want 11011", r); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL neg_latency got %0d want 5", lat); end
    checks++;
    if (bc !== 5) begin errors++; $display("FAIL neg_busy_cycles got %0d want 5", bc); end
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL neg_done_single got %b want 1", p); end
    checks++;
    if ({c, v} !== 2'b00) begin errors++; $display("FAIL neg_flags got %b want 00", {c, v}); end
    do_op5(2'b10, 5'b00000, 5'b00000, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== 7'b0000010) begin
      errors++; $display("FAIL neg_zero got r=%b c=%b v=%b want 00000 1 0", r, c, v);
    end
  endtask

  task automatic test_addsub();
    logic [4:0] r; logic c, v, p; int lat, bc;
    do_op5(2'b01, 5'b00011, 5'b00101, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b11110, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_3_5 got r=%b c=%b v=%b want 11110 0 0", r, c, v);
    end
    do_op5(2'b00, 5'b01111, 5'b00001, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b10000, 1'b0, OVF_ON}) begin
      errors++; $display("FAIL add_ovf got r=%b c=%b v=%b want 10000 0 %b", r, c, v, OVF_ON);
    end
    do_op5(2'b00, 5'b11111, 5'b00001, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b00000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_wrap got r=%b c=%b v=%b want 00000 1 0", r, c, v);
    end
    do_op5(2'b01, 5'b10000, 5'b00001, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b01111, 1'b1, OVF_ON}) begin
      errors++; $display("FAIL sub_ovf got r=%b c=%b v=%b want 01111 1 %b", r, c, v, OVF_ON);
    end
  endtask

  task automatic test_abs();
    logic [4:0] r; logic c, v, p; int lat, bc;
    do_op5(2'b11, 5'b11010, 5'b10101, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b00110, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abs_neg got r=%b c=%b v=%b want 00110 0 0", r, c, v);
    end
    do_op5(2'b11, 5'b00111, 5'b11111, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b00111, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abs_pos got r=%b c=%b v=%b want 00111 0 0", r, c, v);
    end
    do_op5(2'b11, 5'b10000, 5'b00000, r, c, v, lat, bc, p);
    checks++;
    if ({r, c, v} !== {5'b10000, 1'b0, OVF_ON}) begin
      errors++; $display("FAIL abs_min got r=%b c=%b v=%b want 10000 0 %b", r, c, v, OVF_ON);
    end
  endtask

  task automatic test_ignored_start();
    int n;
    start5 = 1'b1; op5 = 2'b00; a5 = 5'b00011; b5 = 5'b00001;
    step();
    start5 = 1'b0;
    step(); step();
    start5 = 1'b1; op5 = 2'b01; a5 = 5'b11111; b5 = 5'b00111;
    step();
    start5 = 1'b0; a5 = 5'b01010; b5 = 5'b01010;
    n = 0;
    while (!done5 && n < 20) begin step(); n++; end
    checks++;
    if (!done5) begin
      errors++; $display("FAIL ignore_timeout got done=0 want 1");
    end
    checks++;
    if (res5 !== 5'b00100) begin
      errors++; $display("FAIL ignore_run_start got %b want 00100", res5);
    end
    // start presented during DONE must not launch an operation
    start5 = 1'b1; op5 = 2'b10; a5 = 5'b00001;
    step();
    start5 = 1'b0;
    step();
    checks++;
    if (busy5 !== 1'b0 || res5 !== 5'b00100) begin
      errors++; $display("FAIL ignore_done_start got busy=%b result=%b want 0 00100", busy5, res5);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] r; logic c, v, p; int lat, bc; int dcnt;
    do_op5(2'b10, 5'b00101, 5'b00000, r, c, v, lat, bc, p);
    start5 = 1'b1; op5 = 2'b10; a5 = 5'b00001; b5 = 5'b00000;
    step();
    start5 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy5, done5, res5, co5, ovf5} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_run got busy=%b done=%b result=%b carry=%b ovf=%b want all 0",
               busy5, done5, res5, co5, ovf5);
    end
    step();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done5) dcnt++;
      step();
    end
    checks++;
    if (dcnt !== 0) begin errors++; $display("FAIL reset_no_done got %0d pulses want 0", dcnt); end
    do_op5(2'b00, 5'b00010, 5'b00011, r, c, v, lat, bc, p);
    checks++;
    if (r !== 5'b00101 || lat !== 5) begin
      errors++; $display("FAIL reset_fresh_start got r=%b lat=%0d want 00101 5", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rnd;
    logic [1:0]  o;
    logic [15:0] av, bv, er;
    logic [16:0] s;
    logic        ev;
    int          n;
    for (int k = 0; k < 1000; k++) begin
      rnd = $urandom();
      o   = rnd[1:0];
      av  = rnd[17:2] ^ rnd[31:16];
      bv  = 16'($urandom());
      if (rnd[5:2] == 4'd0) av = 16'h8000;
      case (o)
        2'b00:   s = {1'b0, av} + {1'b0, bv};
        2'b01:   s = {1'b0, av} + {1'b0, ~bv} + 17'd1;
        2'b10:   s = {1'b0, ~av} + 17'd1;
        default: s = av[15] ? ({1'b0, ~av} + 17'd1) : {1'b0, av};
      endcase
      er = s[15:0];
      case (o)
        2'b00:   ev = (av[15] == bv[15]) && (er[15] != av[15]);
        2'b01:   ev = (av[15] != bv[15]) && (er[15] != av[15]);
        2'b10:   ev = (av == 16'h8000);
        default: ev = (av == 16'h8000);
      endcase
      ev = ev & OVF_ON;
      start16 = 1'b1; op16 = o; a16 = av; b16 = bv;
      step();
      start16 = 1'b0; a16 = 16'($urandom()); b16 = 16'($urandom());
      n = 0;
      while (!done16 && n < 40) begin step(); n++; end
      checks++;
      if (n !== 16 || res16 !== er || co16 !== s[16] || ovf16 !== ev) begin
        errors++;
        $display("FAIL rand16 #%0d op=%b a=%h b=%h got r=%h c=%b v=%b lat=%0d want r=%h c=%b v=%b lat=16",
                 k, o, av, bv, res16, co16, ovf16, n, er, s[16], ev);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_neg();
    test_addsub();
    test_abs();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
